// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0_read;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_read;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              grant0;
    logic              grant1;
    logic              done0;
    logic              done1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side: takes requests and memory status, drives grants and memory strobes
    modport slave (
        input  req0_read, req0_write, req0_addr, req0_wdata,
        input  req1_read, req1_write, req1_addr, req1_wdata,
        input  mem_ready, mem_rdata,
        output grant0, grant1, done0, done1, err, rdata,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata, busy
    );

    // Environment side: requesters and the memory model
    modport master (
        output req0_read, req0_write, req0_addr, req0_wdata,
        output req1_read, req1_write, req1_addr, req1_wdata,
        output mem_ready, mem_rdata,
        input  grant0, grant1, done0, done1, err, rdata,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with timeout
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant0_q;
    logic              grant1_q;
    logic              done0_q;
    logic              done1_q;
    logic              err_q;
    logic              read_en_q;
    logic              write_en_q;
    logic              busy_q;

    logic              active0;
    logic              active1;
    logic              pick;

    // A requester that is being told "done" this cycle is not considered active,
    // so a finished owner cannot immediately re-win on a still-high level request.
    always_comb begin
        active0 = (bus.req0_read | bus.req0_write) & ~done0_q;
        active1 = (bus.req1_read | bus.req1_write) & ~done1_q;
        pick    = (active0 & active1) ? ~last_owner : active1;
    end

    // Two-state transfer FSM; all outputs are registered and change on the falling edge
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (active0 | active1) begin
                        state      <= BUSY;
                        owner      <= pick;
                        last_owner <= pick;
                        wait_cnt   <= 4'd0;
                        grant0_q   <= ~pick;
                        grant1_q   <= pick;
                        busy_q     <= 1'b1;
                        if (pick) begin
                            addr_q     <= bus.req1_addr;
                            wdata_q    <= bus.req1_wdata;
                            write_en_q <= bus.req1_write;
                            read_en_q  <= ~bus.req1_write;
                        end else begin
                            addr_q     <= bus.req0_addr;
                            wdata_q    <= bus.req0_wdata;
                            write_en_q <= bus.req0_write;
                            read_en_q  <= ~bus.req0_write;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready || (wait_cnt == TIMEOUT_CNT)) begin
                        state      <= IDLE;
                        grant0_q   <= 1'b0;
                        grant1_q   <= 1'b0;
                        read_en_q  <= 1'b0;
                        write_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done0_q    <= ~owner;
                        done1_q    <= owner;
                        // A ready in the limit cycle wins over the timeout
                        err_q      <= ~bus.mem_ready;
                        if (bus.mem_ready && read_en_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.grant0       = grant0_q;
    assign bus.grant1       = grant1_q;
    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.mem_read_en  = read_en_q;
    assign bus.mem_write_en = write_en_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic          owner;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mdata;
        int            lat;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    txn_t          exp_q[$];
    txn_t          lat_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          model_last = 1'b1;
    logic [DW-1:0] model_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected transfer goes to the scoreboard; the memory model gets its latency and data
    task automatic push_txn(input logic r, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] md, input int lat);
        txn_t t;
        t.owner = r; t.write = wr; t.addr = a; t.wdata = wd; t.mdata = md; t.lat = lat;
        exp_q.push_back(t);
        lat_q.push_back(t);
        model_last = r;
    endtask

    task automatic clear_reqs();
        bus.req0_read = 1'b0; bus.req0_write = 1'b0;
        bus.req1_read = 1'b0; bus.req1_write = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 300) begin
            @(posedge clk);
            cyc++;
            if (bus.done0 | bus.done1) seen++;
        end
        check("done_wait", 64'(seen), 64'(n));
    endtask

    task automatic run_single(input logic r, input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] md);
        @(posedge clk);
        push_txn(r, wr, a, wd, md, lat);
        if (r) begin
            bus.req1_read = rd; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = wd;
        end else begin
            bus.req0_read = rd; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = wd;
        end
        wait_done(1);
        clear_reqs();
        repeat ($urandom % 3) @(posedge clk);
    endtask

    // Both requesters hold their requests; the scoreboard expects strict alternation
    task automatic setup_contention(input int n);
        logic          first;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        a0 = AW'($urandom); a1 = AW'($urandom); w0 = $urandom; w1 = $urandom;
        first = ~model_last;
        bus.req0_write = 1'b1; bus.req0_addr = a0; bus.req0_wdata = w0;
        bus.req1_read  = 1'b1; bus.req1_addr = a1; bus.req1_wdata = w1;
        for (int i = 0; i < n; i++) begin
            if (first ^ i[0]) push_txn(1'b1, 1'b0, a1, w1, $urandom, 0);
            else              push_txn(1'b0, 1'b1, a0, w0, $urandom, 0);
        end
    endtask

    // Memory model: ready after the transfer's chosen number of wait cycles, noise when idle
    initial begin : memory_model
        logic prev_busy;
        int   cnt;
        txn_t cur;
        prev_busy = 1'b0; cnt = 0;
        cur.lat = 0; cur.mdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                prev_busy = 1'b0;
                bus.mem_ready = 1'b0;
            end else begin
                if (bus.busy) begin
                    if (!prev_busy) begin
                        if (lat_q.size() > 0) cur = lat_q.pop_front();
                        cnt = 0;
                    end
                    bus.mem_ready = (cnt == cur.lat);
                    bus.mem_rdata = cur.mdata;
                    cnt++;
                end else begin
                    bus.mem_ready = 1'($urandom);
                    bus.mem_rdata = $urandom;
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Monitor: checks grant-time outputs at the start of BUSY and completion on done
    initial begin : monitor
        logic prev_busy;
        int   bcnt;
        bit   in_flight;
        logic exp_err;
        txn_t e;
        prev_busy = 1'b0; bcnt = 0; in_flight = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (in_flight) begin
                    void'(exp_q.pop_front());
                    in_flight = 1'b0;
                end
                model_rdata = '0;
                prev_busy = 1'b0;
            end else begin
                if (bus.done0 | bus.done1) begin
                    check("done_expected", 64'(in_flight), 64'd1);
                    if (in_flight && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        in_flight = 1'b0;
                        exp_err = (e.lat >= 16);
                        check("done_owner", {62'd0, bus.done1, bus.done0}, e.owner ? 64'd2 : 64'd1);
                        check("err", 64'(bus.err), 64'(exp_err));
                        check("busy_cycles", 64'(bcnt), exp_err ? 64'd16 : 64'(e.lat + 1));
                        if (!e.write && !exp_err) model_rdata = e.mdata;
                        check("rdata", 64'(bus.rdata), 64'(model_rdata));
                    end
                end else begin
                    check("err_without_done", 64'(bus.err), 64'd0);
                end
                if (bus.busy && !prev_busy) begin
                    bcnt = 0;
                    check("grant_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        in_flight = 1'b1;
                        check("grant", {62'd0, bus.grant1, bus.grant0}, e.owner ? 64'd2 : 64'd1);
                        check("mem_en", {62'd0, bus.mem_write_en, bus.mem_read_en}, e.write ? 64'd2 : 64'd1);
                        check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                        check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
                    end
                end
                if (bus.busy) bcnt++;
                prev_busy = bus.busy;
            end
        end
    end

    initial begin : stimulus
        int c;
        int lat;
        int op;
        clear_reqs();
        bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_addr = '0; bus.req1_wdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_ctrl", {56'd0, bus.grant0, bus.grant1, bus.done0, bus.done1, bus.err,
                             bus.mem_read_en, bus.mem_write_en, bus.busy}, 64'd0);
        check("reset_mem", {22'd0, bus.mem_addr, bus.mem_wdata}, 64'd0);
        check("reset_rdata", 64'(bus.rdata), 64'd0);
        @(posedge clk);
        rst = 1'b1;

        run_single(1'b0, 1'b1, 1'b0, 10'h005, 32'h0, 2, 32'hDEADBEEF);
        run_single(1'b1, 1'b1, 1'b1, 10'h0A3, 32'h12345678, 0, $urandom);
        run_single(1'b0, 1'b1, 1'b0, 10'h111, 32'h0, 20, $urandom);
        run_single(1'b0, 1'b1, 1'b0, 10'h222, 32'h0, 15, 32'hCAFEF00D);
        run_single(1'b1, 1'b0, 1'b1, 10'h333, 32'hA5A5A5A5, 16, $urandom);

        for (int i = 0; i < 25; i++) begin
            case ($urandom % 8)
                0, 1, 2, 3: lat = int'($urandom % 3);
                4:          lat = int'($urandom_range(3, 14));
                5:          lat = 15;
                6:          lat = 16;
                default:    lat = int'($urandom_range(17, 25));
            endcase
            op = int'($urandom_range(1, 3));
            run_single(1'($urandom), 1'(op), 1'(op >> 1), AW'($urandom), $urandom, lat, $urandom);
        end

        // Reset in the second BUSY cycle aborts the transfer silently
        @(posedge clk);
        push_txn(1'b0, 1'b0, 10'h3C4, 32'h0, $urandom, 30);
        bus.req0_read = 1'b1; bus.req0_addr = 10'h3C4; bus.req0_wdata = 32'h0;
        c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (!bus.busy && c < 20);
        check("abort_busy_seen", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ctrl", {56'd0, bus.grant0, bus.grant1, bus.done0, bus.done1, bus.err,
                             bus.mem_read_en, bus.mem_write_en, bus.busy}, 64'd0);
        check("abort_regs", {22'd0, bus.mem_addr, bus.mem_wdata}, 64'd0);
        check("abort_rdata", 64'(bus.rdata), 64'd0);
        clear_reqs();
        model_last = 1'b1;
        @(posedge clk);
        setup_contention(4);
        @(posedge clk);
        rst = 1'b1;
        wait_done(4);
        clear_reqs();
        repeat (2) @(posedge clk);

        run_single(1'b1, 1'b1, 1'b0, AW'($urandom), $urandom, 1, $urandom);
        @(posedge clk);
        setup_contention(6);
        wait_done(6);
        clear_reqs();

        c = 0;
        while (exp_q.size() > 0 && c < 50) begin
            @(posedge clk);
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
